uart_tx_stream: RTL and testbench

- Synthesizable 8N1 UART transmitter with a small input FIFO.
- Sits directly upstream of the 8N1 serial receiver/display model on the serial line.
- Accepts bytes over a valid/ready stream from firmware-side or testbench logic and serializes them onto ser_tx, LSB first, idle high.
- Lets benches and user-project logic push strings without per-bit pacing.

---
 rtl/uart_tx_stream.sv | 137 +++++++++++++
 tb/tb_uart_tx_stream.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_stream.sv
// 8N1 UART transmitter fed by a small valid/ready FIFO.
// ser_tx is registered; frames run back to back whenever a byte is queued at the end of a stop bit.
module uart_tx_stream #(
    parameter int CLKS_PER_BIT = 5,
    parameter int FIFO_AW      = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_tx,
    output logic             busy,
    output logic             tx_done,
    output logic [FIFO_AW:0] fifo_level
);

    // state | meaning
    // IDLE  | line high, waiting for a queued byte
    // START | start bit, line low
    // DATA  | eight data bits, LSB first
    // STOP  | stop bit, line high; last cycle pops the next byte if one is queued
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int DW    = ($clog2(CLKS_PER_BIT + 1) > 1) ? $clog2(CLKS_PER_BIT + 1) : 1;
    localparam logic [DW-1:0]    DIV_LAST   = DW'(CLKS_PER_BIT - 1);
    localparam logic [FIFO_AW:0] LEVEL_FULL = {1'b1, {FIFO_AW{1'b0}}};

    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [1:0]         state;
    logic [7:0]         shift;
    logic [2:0]         bit_cnt;
    logic [DW-1:0]      div;
    logic               push;
    logic               pop;
    logic               div_last;
    logic               fifo_empty;

    // in_ready comes from the registered level only, so a pop never frees a slot in the same cycle
    assign in_ready   = (fifo_level != LEVEL_FULL);
    assign push       = in_valid && in_ready;
    assign fifo_empty = (fifo_level == '0);
    assign div_last   = (div == DIV_LAST);
    assign pop        = !fifo_empty && ((state == IDLE) || ((state == STOP) && div_last));
    assign busy       = (state != IDLE);
    assign tx_done    = (state == STOP) && div_last;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + FIFO_AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + FIFO_AW'(1);
            end
            if (push && !pop) begin
                fifo_level <= fifo_level + (FIFO_AW+1)'(1);
            end else if (pop && !push) begin
                fifo_level <= fifo_level - (FIFO_AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            shift   <= '0;
            bit_cnt <= '0;
            div     <= '0;
            ser_tx  <= 1'b1;
        end else if (pop) begin
            // pop happens only in IDLE or on the last stop cycle; both lead straight into START
            shift   <= mem[rd_ptr];
            bit_cnt <= '0;
            div     <= '0;
            ser_tx  <= 1'b0;
            state   <= START;
        end else begin
            case (state)
                START: begin
                    if (div_last) begin
                        div    <= '0;
                        ser_tx <= shift[0];
                        state  <= DATA;
                    end else begin
                        div <= div + DW'(1);
                    end
                end
                DATA: begin
                    if (div_last) begin
                        div <= '0;
                        if (bit_cnt == 3'd7) begin
                            ser_tx <= 1'b1;
                            state  <= STOP;
                        end else begin
                            shift   <= {1'b0, shift[7:1]};
                            bit_cnt <= bit_cnt + 3'd1;
                            ser_tx  <= shift[1];
                        end
                    end else begin
                        div <= div + DW'(1);
                    end
                end
                STOP: begin
                    if (div_last) begin
                        div   <= '0;
                        state <= IDLE;
                    end else begin
                        div <= div + DW'(1);
                    end
                end
                default: begin
                    div    <= '0;
                    ser_tx <= 1'b1;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_stream.sv
// Bench for uart_tx_stream: frame-level reference model, serial receiver, vector table and corner sequences.
module tb_uart_tx_stream;

    localparam int CPB0   = 5;
    localparam int AW0    = 2;
    localparam int DEPTH0 = 4;
    localparam int FRAME0 = 10 * CPB0;

    logic           clk = 1'b0;
    logic           resetn = 1'b0;
    logic [7:0]     in_data = 8'h00;
    logic           in_valid = 1'b0;
    logic           in_ready, ser_tx, busy, tx_done;
    logic [AW0:0]   fifo_level;

    logic [7:0]     d1_data = 8'h00;
    logic           d1_valid = 1'b0;
    logic           d1_ready, d1_tx, d1_busy, d1_done;
    logic [1:0]     d1_level;
    logic [7:0]     d2_data = 8'h00;
    logic           d2_valid = 1'b0;
    logic           d2_ready, d2_tx, d2_busy, d2_done;
    logic [1:0]     d2_level;

    always #5 clk = ~clk;

    uart_tx_stream #(.CLKS_PER_BIT(CPB0), .FIFO_AW(AW0)) dut (
        .clk(clk), .resetn(resetn), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .ser_tx(ser_tx), .busy(busy), .tx_done(tx_done), .fifo_level(fifo_level)
    );
    uart_tx_stream #(.CLKS_PER_BIT(2), .FIFO_AW(1)) dut_fast (
        .clk(clk), .resetn(resetn), .in_data(d1_data), .in_valid(d1_valid), .in_ready(d1_ready),
        .ser_tx(d1_tx), .busy(d1_busy), .tx_done(d1_done), .fifo_level(d1_level)
    );
    uart_tx_stream #(.CLKS_PER_BIT(16), .FIFO_AW(1)) dut_slow (
        .clk(clk), .resetn(resetn), .in_data(d2_data), .in_valid(d2_valid), .in_ready(d2_ready),
        .ser_tx(d2_tx), .busy(d2_busy), .tx_done(d2_done), .fifo_level(d2_level)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: the line is a sequence of 10*CPB-cycle frames; a queued byte starts a frame
    // when the line is idle or the previous frame is in its last cycle.
    int         m_lvl = 0;
    int         m_pos = 0;
    logic [7:0] m_cur = 8'h00;
    logic [7:0] m_q[$];
    logic [7:0] m_hist[$];

    always @(posedge clk) begin
        bit acc;
        bit pop;
        if (!resetn) begin
            m_lvl = 0;
            m_pos = 0;
            m_q.delete();
        end else begin
            pop = ((m_pos == 0) || (m_pos == FRAME0)) && (m_lvl != 0);
            acc = in_valid && (m_lvl != DEPTH0);
            if (acc) begin
                m_q.push_back(in_data);
                m_hist.push_back(in_data);
            end
            if (pop) begin
                m_cur = m_q.pop_front();
                m_pos = 1;
            end else if (m_pos == FRAME0) begin
                m_pos = 0;
            end else if (m_pos != 0) begin
                m_pos++;
            end
            m_lvl = m_lvl + int'(acc) - int'(pop);
        end
    end

    always @(negedge clk) begin
        logic       exp_tx;
        int         idx;
        logic [6:0] exp_v;
        if (!resetn) begin
            m_lvl = 0;
            m_pos = 0;
            m_q.delete();
        end
        exp_tx = 1'b1;
        if (m_pos != 0) begin
            idx = (m_pos - 1) / CPB0;
            if (idx == 0) exp_tx = 1'b0;
            else if (idx <= 8) exp_tx = m_cur[idx-1];
        end
        exp_v = {exp_tx, (m_pos != 0), (m_pos == FRAME0), (m_lvl != DEPTH0), 3'(m_lvl)};
        check("cycle", {25'd0, ser_tx, busy, tx_done, in_ready, fifo_level}, {25'd0, exp_v});
    end

    // Independent 8N1 receiver sampling mid-bit
    int         rx_cnt  = 0;
    int         rx_ferr = 0;
    logic [7:0] rx_sh   = 8'h00;
    logic [7:0] rx_q[$];

    always @(negedge clk) begin
        int b;
        if (!resetn) begin
            rx_cnt = 0;
        end else begin
            if (rx_cnt == 0) begin
                if (ser_tx == 1'b0) rx_cnt = 1;
            end else begin
                rx_cnt++;
            end
            if (rx_cnt != 0 && ((rx_cnt - 1) % CPB0) == CPB0 / 2) begin
                b = (rx_cnt - 1) / CPB0;
                if (b == 0) begin
                    if (ser_tx !== 1'b0) rx_ferr++;
                end else if (b <= 8) begin
                    rx_sh[b-1] = ser_tx;
                end else begin
                    if (ser_tx !== 1'b1) rx_ferr++;
                    rx_q.push_back(rx_sh);
                end
            end
            if (rx_cnt == FRAME0) rx_cnt = 0;
        end
    end

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;
    } vec_t;

    vec_t vecs[6];

    task automatic push_one(input logic [7:0] d);
        in_data  = d;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic observe(input int ncyc, output int first_low, output int busy_cyc, output int busy_runs,
                           output int done_cnt, output int done_at, output logic [9:0] frame);
        logic prev_busy;
        first_low = -1; busy_cyc = 0; busy_runs = 0; done_cnt = 0; done_at = -1; frame = '1;
        prev_busy = 1'b0;
        for (int n = 1; n <= ncyc; n++) begin
            @(negedge clk);
            if (busy) busy_cyc++;
            if (busy && !prev_busy) busy_runs++;
            prev_busy = busy;
            if (tx_done) begin
                done_cnt++;
                done_at = n;
            end
            if (first_low < 0 && ser_tx == 1'b0) first_low = n;
            if (first_low > 0 && ((n - first_low) % CPB0) == 2 && ((n - first_low) / CPB0) < 10)
                frame[(n - first_low) / CPB0] = ser_tx;
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while ((busy !== 1'b0 || fifo_level !== '0) && n < limit) begin
            @(posedge clk); #1;
            n++;
        end
        check("idle_timeout", 32'(n < limit), 32'd1);
    endtask

    task automatic send(input logic [7:0] bytes[$]);
        int   i = 0;
        int   guard = 0;
        logic r;
        in_valid = 1'b1;
        while (i < bytes.size() && guard < 5000) begin
            in_data = bytes[i];
            r = in_ready;
            @(posedge clk); #1;
            if (r) i++;
            guard++;
        end
        in_valid = 1'b0;
        check("send_all", i, bytes.size());
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         fl, bc, br, dc, da, acc, idx, n;
        int         b1, b2, a1, a2;
        logic       r, r1, r2;
        logic [9:0] fr;
        logic [7:0] hello[$];

        vecs[0] = '{8'h55, 10'h2AA};
        vecs[1] = '{8'h00, 10'h200};
        vecs[2] = '{8'hFF, 10'h3FE};
        vecs[3] = '{8'hA5, 10'h34A};
        vecs[4] = '{8'h01, 10'h202};
        vecs[5] = '{8'h80, 10'h300};

        repeat (3) @(posedge clk);
        #1;
        check("reset_state", {27'd0, ser_tx, busy, tx_done, in_ready, fifo_level},
              {27'd0, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0});
        resetn = 1'b1;
        @(posedge clk); #1;

        // single frames from the vector table
        foreach (vecs[i]) begin
            push_one(vecs[i].data);
            observe(60, fl, bc, br, dc, da, fr);
            check("frame_bits", fr, vecs[i].frame);
            check("start_latency", fl, 2);
            check("busy_len", bc, FRAME0);
            check("done_cnt", dc, 1);
            check("done_at", da, fl + FRAME0 - 1);
            wait_idle(100);
        end

        // back-to-back frames
        rx_q.delete();
        in_data = 8'h48; in_valid = 1'b1;
        @(posedge clk); #1;
        in_data = 8'h0A;
        @(posedge clk); #1;
        in_valid = 1'b0;
        observe(120, fl, bc, br, dc, da, fr);
        check("b2b_busy_len", bc, 2 * FRAME0);
        check("b2b_busy_runs", br, 1);
        check("b2b_done_cnt", dc, 2);
        check("b2b_rx_count", rx_q.size(), 2);
        if (rx_q.size() == 2) begin
            check("b2b_byte0", rx_q[0], 8'h48);
            check("b2b_byte1", rx_q[1], 8'h0A);
        end
        wait_idle(100);

        // fill the FIFO while holding in_valid
        rx_q.delete();
        acc = 0; idx = 0;
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            in_data = 8'(8'h30 + idx);
            r = in_ready;
            @(posedge clk); #1;
            if (r) begin
                acc++;
                idx++;
            end
        end
        check("full_accepts", acc, 5);
        check("full_ready", in_ready, 1'b0);
        check("full_level", fifo_level, 3'd4);
        n = 0;
        while (idx < 6 && n < 1000) begin
            in_data = 8'(8'h30 + idx);
            r = in_ready;
            @(posedge clk); #1;
            if (r) idx++;
            n++;
        end
        in_valid = 1'b0;
        check("full_all_sent", idx, 6);
        wait_idle(600);
        check("full_rx_count", rx_q.size(), 6);
        for (int i = 0; i < rx_q.size() && i < 6; i++)
            check("full_order", rx_q[i], 8'(8'h30 + i));

        // reset in the middle of data bit 3
        rx_q.delete();
        push_one(8'hA5);
        push_one(8'h77);
        repeat (22) @(posedge clk);
        #1;
        check("pre_reset", {29'd0, ser_tx, busy, fifo_level}, {29'd0, 1'b0, 1'b1, 3'd1});
        #2;
        resetn = 1'b0;
        #1;
        check("mid_reset", {27'd0, ser_tx, busy, tx_done, in_ready, fifo_level},
              {27'd0, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0});
        @(posedge clk);
        @(posedge clk); #1;
        resetn = 1'b1;
        rx_q.delete();
        push_one(8'h41);
        wait_idle(100);
        check("post_reset_count", rx_q.size(), 1);
        if (rx_q.size() == 1) check("post_reset_byte", rx_q[0], 8'h41);

        // loopback of "Hello\n"
        rx_q.delete();
        rx_ferr = 0;
        hello = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h0A};
        send(hello);
        wait_idle(600);
        check("hello_count", rx_q.size(), 6);
        for (int i = 0; i < rx_q.size() && i < 6; i++)
            check("hello_byte", rx_q[i], hello[i]);
        check("hello_framing", rx_ferr, 0);

        // random traffic: sparse phase then dense phase
        rx_q.delete();
        m_hist.delete();
        for (int c = 0; c < 3000; c++) begin
            in_valid = ($urandom_range(0, 99) < ((c < 1500) ? 4 : 40));
            in_data  = 8'($urandom);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        wait_idle(2000);
        check("rand_count", rx_q.size(), m_hist.size());
        for (int i = 0; i < rx_q.size() && i < m_hist.size(); i++)
            check("rand_byte", rx_q[i], m_hist[i]);
        check("rand_framing", rx_ferr, 0);

        // parameter sweep: frame length and depth-2 FIFO
        d1_data = 8'hC3; d2_data = 8'hC3;
        d1_valid = 1'b1; d2_valid = 1'b1;
        @(posedge clk); #1;
        d1_valid = 1'b0; d2_valid = 1'b0;
        b1 = 0; b2 = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (d1_busy) b1++;
            if (d2_busy) b2++;
        end
        @(posedge clk); #1;
        check("fast_frame_len", b1, 20);
        check("slow_frame_len", b2, 160);

        a1 = 0; a2 = 0;
        d1_valid = 1'b1; d2_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            d1_data = 8'(c); d2_data = 8'(c);
            r1 = d1_ready; r2 = d2_ready;
            @(posedge clk); #1;
            if (r1) a1++;
            if (r2) a2++;
        end
        d1_valid = 1'b0; d2_valid = 1'b0;
        check("fast_accepts", a1, 3);
        check("slow_accepts", a2, 3);
        check("fast_full", {d1_ready, d1_level}, {1'b0, 2'd2});
        check("slow_full", {d2_ready, d2_level}, {1'b0, 2'd2});
        n = 0;
        while ((d1_busy || d2_busy || d1_level != 2'd0 || d2_level != 2'd0) && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        check("sweep_drain", 32'(n < 1000), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
